// File: rtl/qmult_seq.sv
// qmult_seq: sequential sign-magnitude fixed-point multiplier (Q(N-1-Q).Q format)
//   Ports:
//     i_clk           - sole clock, rising edge
//     i_reset_n       - asynchronous active-low reset
//     i_multiplicand  - operand A, bit N-1 sign, bits N-2:0 magnitude
//     i_multiplier    - operand B, same format as A
//     i_start         - level request; sampled in IDLE/DONE to capture operands
//     o_result        - sign-magnitude product, same format as operands
//     o_complete      - result valid, held in DONE until the next capture
//     o_overflow      - product magnitude saturated on the last result
//     o_busy          - shift-add iteration in progress
module qmult_seq #(
    parameter int Q = 8,
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    input  logic         i_start,
    output logic [N-1:0] o_result,
    output logic         o_complete,
    output logic         o_overflow,
    output logic         o_busy
);
    localparam int M  = N - 1;
    localparam int W  = 2 * M;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   a_q, a_d;
    logic [M-1:0]   b_q, b_d;
    logic           sign_q, sign_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   res_q, res_d;
    logic           ovf_q, ovf_d;
    logic           cmp_q, cmp_d;
    logic           acc_ovf;
    logic [M-1:0]   res_mag;

    // Any accumulator bit above the integer field means the product does not fit.
    assign acc_ovf = |acc_q[W-1:Q+M];
    assign res_mag = acc_ovf ? {M{1'b1}} : acc_q[Q+M-1:Q];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        cmp_d   = cmp_q;
        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    a_d     = {{M{1'b0}}, i_multiplicand[M-1:0]};
                    b_d     = i_multiplier[M-1:0];
                    sign_d  = i_multiplicand[N-1] ^ i_multiplier[N-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    cmp_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(M)) begin
                    // All magnitude bits consumed: publish; a zero magnitude is always positive.
                    res_d   = {sign_q & (|res_mag), res_mag};
                    ovf_d   = acc_ovf;
                    cmp_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    // LSB-first shift-add: multiplicand moves left, multiplier right.
                    acc_d = acc_q + (b_q[0] ? a_q : '0);
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            cmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            cmp_q   <= cmp_d;
        end
    end

    assign o_result   = res_q;
    assign o_overflow = ovf_q;
    assign o_complete = cmp_q;
    assign o_busy     = (state_q == RUN);
endmodule
